// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues sequential word reads, tracks them through a
// fixed-latency pipe and buffers {insn, pc} pairs in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 4,
    parameter int                MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h8002_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       srec_parse_in,
    input  logic                       stall_in,
    input  logic                       redirect_in,
    input  logic [ADDR_W-1:0]          redirect_pc_in,
    output logic                       mem_req_out,
    output logic [ADDR_W-1:0]          mem_addr_out,
    output logic                       mem_rw_out,
    output logic [1:0]                 mem_access_size_out,
    input  logic [DATA_W-1:0]          mem_data_in,
    output logic                       insn_valid_out,
    output logic [DATA_W-1:0]          insn_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]     occupancy_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + $clog2(MEM_LATENCY + 1) + 1;

    logic [ADDR_W-1:0]      pc_q;
    logic [MEM_LATENCY-1:0] pv_q;
    logic [MEM_LATENCY-1:0] pv_d;
    logic [ADDR_W-1:0]      ppc_q [MEM_LATENCY];
    logic [ADDR_W-1:0]      ppc_d [MEM_LATENCY];
    logic [DATA_W-1:0]      fd_q  [DEPTH];
    logic [ADDR_W-1:0]      fp_q  [DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [CW-1:0]          cnt_q;

    logic [SW-1:0]          inflight_s;
    logic [SW-1:0]          credit_s;
    logic                   issue_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   valid_s;

    // Credit check: buffered plus in-flight entries must leave room for one more.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_s = inflight_s + SW'(pv_q[i]);
        end
        credit_s = SW'(cnt_q) + inflight_s;
        if (rst_n && !srec_parse_in && !redirect_in && (credit_s < SW'(DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign push_s  = pv_q[MEM_LATENCY-1];
    assign valid_s = (cnt_q != '0);
    assign pop_s   = valid_s && !stall_in;

    // Next state of the request-tracking shift pipe.
    always_comb begin
        pv_d[0]  = issue_s;
        ppc_d[0] = pc_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            ppc_d[i] = ppc_q[i-1];
        end
    end

    // Fetch PC, tracking pipe and FIFO pointers; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            pv_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                ppc_q[i] <= '0;
            end
        end else if (redirect_in) begin
            pc_q  <= redirect_pc_in;
            pv_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= issue_s ? pc_q + ADDR_W'(4) : pc_q;
            pv_q  <= pv_d;
            ppc_q <= ppc_d;
            wr_q  <= push_s ? wr_q + AW'(1) : wr_q;
            rd_q  <= pop_s ? rd_q + AW'(1) : rd_q;
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; the entry leaving the pipe captures this cycle's read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fd_q[i] <= '0;
                fp_q[i] <= '0;
            end
        end else if (push_s && !redirect_in) begin
            fd_q[wr_q] <= mem_data_in;
            fp_q[wr_q] <= ppc_q[MEM_LATENCY-1];
        end else begin
            fd_q <= fd_q;
            fp_q <= fp_q;
        end
    end

    assign mem_req_out         = issue_s;
    assign mem_addr_out        = rst_n ? pc_q : '0;
    assign mem_rw_out          = 1'b0;
    assign mem_access_size_out = 2'b00;
    assign insn_valid_out      = valid_s;
    assign insn_out            = valid_s ? fd_q[rd_q] : '0;
    assign pc_out              = valid_s ? fp_q[rd_q] : '0;
    assign occupancy_out       = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: two configurations (D4/L1 and D8/L3) driven by
// directed phases then random stall/srec/redirect traffic against a queue-based model.
module tb_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        int          vis;
    } ent_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int D  = (g == 0) ? 4 : 8;
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int CW = $clog2(D) + 1;

        logic          rst_n, srec, stall, redir;
        logic [31:0]   rpc;
        logic          req, rw, iv;
        logic [1:0]    sz;
        logic [31:0]   addr, mdata, insn, pco, tmp;
        logic [CW-1:0] occ;
        logic [31:0]   mdl [L];
        ent_t          q[$];
        logic [31:0]   pc_m;
        int            cyc = 0;
        int            vis;
        logic          exp_req;
        bit            fin = 1'b0;

        fetch_queue #(
            .ADDR_W(32), .DATA_W(32), .DEPTH(D), .MEM_LATENCY(L), .RESET_PC(32'h8002_0000)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .srec_parse_in(srec), .stall_in(stall),
            .redirect_in(redir), .redirect_pc_in(rpc), .mem_req_out(req),
            .mem_addr_out(addr), .mem_rw_out(rw), .mem_access_size_out(sz),
            .mem_data_in(mdata), .insn_valid_out(iv), .insn_out(insn),
            .pc_out(pco), .occupancy_out(occ)
        );

        // Memory model: returns mem_fn(address) exactly L cycles after it was presented.
        always @(posedge clk) begin
            mdl[0] <= addr;
            for (int i = 1; i < L; i++) mdl[i] <= mdl[i-1];
        end
        assign mdata = mem_fn(mdl[L-1]);

        // Monitor: compare DUT outputs with the model, then advance the model.
        always @(negedge clk) begin
            cyc++;
            if (rst_n !== 1'b1) begin
                chk("reset_outputs", {iv, req, occ == '0, addr, pco}, {1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
                chk("reset_insn", {32'h0, insn}, 64'h0);
                q.delete();
                pc_m = 32'h8002_0000;
            end else begin
                vis = 0;
                foreach (q[i]) if (q[i].vis <= cyc) vis++;
                chk("insn_valid", {63'h0, iv}, {63'h0, vis > 0});
                chk("occupancy", 64'(occ), 64'(vis));
                if (vis > 0) begin
                    chk("pc_out", {32'h0, pco}, {32'h0, q[0].pc});
                    chk("insn_out", {32'h0, insn}, {32'h0, q[0].insn});
                end
                exp_req = !srec && !redir && (q.size() < D);
                chk("mem_req", {63'h0, req}, {63'h0, exp_req});
                chk("rw_size", {61'h0, rw, sz}, 64'h0);
                if (exp_req) begin
                    chk("mem_addr", {32'h0, addr}, {32'h0, pc_m});
                    q.push_back('{pc_m, mem_fn(pc_m), cyc + L + 1});
                    pc_m = pc_m + 32'd4;
                end
                if (vis > 0 && !stall) void'(q.pop_front());
                if (redir) begin
                    q.delete();
                    pc_m = rpc;
                end
            end
        end

        task automatic wait_c(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        initial begin
            rst_n = 1'b0; srec = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
            wait_c(3);
            rst_n = 1'b1;
            wait_c(12);
            stall = 1'b1; wait_c(12); stall = 1'b0; wait_c(6);
            redir = 1'b1; rpc = 32'h8002_0100; wait_c(1); redir = 1'b0; wait_c(8);
            wait_c(1); srec = 1'b1; wait_c(10); srec = 1'b0; wait_c(6);
            stall = 1'b1; wait_c(3);
            rst_n = 1'b0; wait_c(2); rst_n = 1'b1; stall = 1'b0; wait_c(8);
            redir = 1'b1; rpc = 32'hFFFF_FFF8; wait_c(1); redir = 1'b0;
            for (int i = 0; i < 400; i++) begin
                stall = ($urandom_range(0, 99) < 50);
                srec  = ($urandom_range(0, 99) < 8);
                redir = ($urandom_range(0, 99) < 3);
                tmp   = $urandom();
                rpc   = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : {tmp[31:2], 2'b00};
                wait_c(1);
            end
            redir = 1'b0; srec = 1'b0; stall = 1'b0;
            wait_c(10);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 5000; i++) begin
            if (cfg[0].fin && cfg[1].fin) break;
            @(posedge clk);
        end
        if (!(cfg[0].fin && cfg[1].fin)) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: stimulus done=%0b%0b expected 11", cfg[0].fin, cfg[1].fin);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
